// File: rtl/core6502_pkg.sv
// Shared definitions for the Core6502 datapath blocks.
package core6502_pkg;

  localparam int unsigned PC_W = 8;

  typedef struct packed {
    logic adl_pcl;
    logic pcl_pcl;
    logic adh_pch;
    logic pch_pch;
    logic i_pc;
    logic pcl_adl;
    logic pch_adh;
    logic pcl_db;
    logic pch_db;
  } pc_cmd_t;

endpackage

// File: rtl/pc_half.sv
// One half of the program counter: bus/recirculate source mux, +cin adder, carry out.
module pc_half
  import core6502_pkg::*;
#(
  parameter int unsigned W = PC_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ld_i,
  input  logic [W-1:0] bus_i,
  input  logic         cin_i,
  output logic [W-1:0] q_o,
  output logic         cout_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] src;
  logic [W-1:0] q_d;

  always_comb begin
    src    = ld_i ? bus_i : q_q;
    q_d    = src + {{(W-1){1'b0}}, cin_i};
    cout_o = cin_i & (&src);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: two chained PC halves, bus drive muxes, carry and command-error flags.
module pc_unit
  import core6502_pkg::*;
#(
  parameter int unsigned W = PC_W
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic [W-1:0] ADL,
  input  logic [W-1:0] ADH,
  input  logic         ADL_PCL,
  input  logic         PCL_PCL,
  input  logic         ADH_PCH,
  input  logic         PCH_PCH,
  input  logic         I_PC,
  input  logic         PCL_ADL,
  input  logic         PCH_ADH,
  input  logic         PCL_DB,
  input  logic         PCH_DB,
  output logic [W-1:0] PCL,
  output logic [W-1:0] PCH,
  output logic [W-1:0] ADL_o,
  output logic         ADL_oe,
  output logic [W-1:0] ADH_o,
  output logic         ADH_oe,
  output logic [W-1:0] DB_o,
  output logic         DB_oe,
  output logic         PCC,
  output logic         CMD_ERR
);

  pc_cmd_t cmd;
  logic    pcl_cout;
  logic    pch_cout_unused;
  logic    conflict;
  logic    pcc_q, pcc_d;
  logic    err_q, err_d;

  always_comb begin
    cmd = '{adl_pcl: ADL_PCL, pcl_pcl: PCL_PCL, adh_pch: ADH_PCH, pch_pch: PCH_PCH,
            i_pc: I_PC, pcl_adl: PCL_ADL, pch_adh: PCH_ADH, pcl_db: PCL_DB, pch_db: PCH_DB};
  end

  pc_half #(.W(W)) u_pcl (
    .clk_i  (CLK),
    .rst_i  (RES),
    .ld_i   (cmd.adl_pcl),
    .bus_i  (ADL),
    .cin_i  (cmd.i_pc),
    .q_o    (PCL),
    .cout_o (pcl_cout)
  );

  // PCH only ever advances through the PCL carry.
  pc_half #(.W(W)) u_pch (
    .clk_i  (CLK),
    .rst_i  (RES),
    .ld_i   (cmd.adh_pch),
    .bus_i  (ADH),
    .cin_i  (pcl_cout),
    .q_o    (PCH),
    .cout_o (pch_cout_unused)
  );

  always_comb begin
    conflict = (cmd.adl_pcl & cmd.pcl_pcl) |
               (cmd.adh_pch & cmd.pch_pch) |
               (cmd.pcl_db  & cmd.pch_db);
    pcc_d    = pcl_cout;
    err_d    = err_q | conflict;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      pcc_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pcc_q <= pcc_d;
      err_q <= err_d;
    end
  end

  always_comb begin
    ADL_o  = PCL;
    ADL_oe = cmd.pcl_adl;
    ADH_o  = PCH;
    ADH_oe = cmd.pch_adh;
    DB_o   = cmd.pcl_db ? PCL : PCH;
    DB_oe  = cmd.pcl_db | cmd.pch_db;
  end

  assign PCC     = pcc_q;
  assign CMD_ERR = err_q;

endmodule

// File: tb/tb_pc_unit.sv
// Randomized self-checking bench for pc_unit against a 16-bit arithmetic PC model.
module tb_pc_unit;

  logic       CLK = 1'b0;
  logic       RES;
  logic [7:0] ADL, ADH;
  logic       ADL_PCL, PCL_PCL, ADH_PCH, PCH_PCH, I_PC;
  logic       PCL_ADL, PCH_ADH, PCL_DB, PCH_DB;
  logic [7:0] PCL, PCH, ADL_o, ADH_o, DB_o;
  logic       ADL_oe, ADH_oe, DB_oe, PCC, CMD_ERR;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] m_pc;
  logic        m_pcc;
  logic        m_err;
  bit          m_valid = 1'b0;

  pc_unit #(.W(8)) dut (
    .CLK(CLK), .RES(RES), .ADL(ADL), .ADH(ADH),
    .ADL_PCL(ADL_PCL), .PCL_PCL(PCL_PCL), .ADH_PCH(ADH_PCH), .PCH_PCH(PCH_PCH),
    .I_PC(I_PC), .PCL_ADL(PCL_ADL), .PCH_ADH(PCH_ADH), .PCL_DB(PCL_DB), .PCH_DB(PCH_DB),
    .PCL(PCL), .PCH(PCH), .ADL_o(ADL_o), .ADL_oe(ADL_oe), .ADH_o(ADH_o), .ADH_oe(ADH_oe),
    .DB_o(DB_o), .DB_oe(DB_oe), .PCC(PCC), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // cmd bit order: {ADL_PCL,PCL_PCL,ADH_PCH,PCH_PCH,I_PC,PCL_ADL,PCH_ADH,PCL_DB,PCH_DB}
  task automatic cycle(input logic r, input logic [7:0] al, input logic [7:0] ah,
                       input logic [8:0] c);
    logic [7:0] lo, hi;
    @(negedge CLK);
    RES = r; ADL = al; ADH = ah;
    {ADL_PCL, PCL_PCL, ADH_PCH, PCH_PCH, I_PC, PCL_ADL, PCH_ADH, PCL_DB, PCH_DB} = c;
    #1;
    check("ADL_oe", {15'd0, ADL_oe}, {15'd0, c[3]});
    check("ADH_oe", {15'd0, ADH_oe}, {15'd0, c[2]});
    check("DB_oe",  {15'd0, DB_oe},  {15'd0, c[1] | c[0]});
    if (m_valid) begin
      check("ADL_o", {8'd0, ADL_o}, {8'd0, m_pc[7:0]});
      check("ADH_o", {8'd0, ADH_o}, {8'd0, m_pc[15:8]});
      check("DB_o",  {8'd0, DB_o},  {8'd0, c[1] ? m_pc[7:0] : m_pc[15:8]});
    end
    @(posedge CLK);
    if (r) begin
      m_pc = '0; m_pcc = 1'b0; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      lo    = c[8] ? al : m_pc[7:0];
      hi    = c[6] ? ah : m_pc[15:8];
      m_pcc = c[4] && (lo == 8'hFF);
      m_pc  = {hi, lo} + {15'd0, c[4]};
      m_err = m_err | (c[8] & c[7]) | (c[6] & c[5]) | (c[1] & c[0]);
    end
    #1;
    if (m_valid) begin
      check("PC",      {PCH, PCL}, m_pc);
      check("PCC",     {15'd0, PCC}, {15'd0, m_pcc});
      check("CMD_ERR", {15'd0, CMD_ERR}, {15'd0, m_err});
    end
  endtask

  localparam logic [8:0] C_NONE = 9'b0;
  localparam logic [8:0] C_LD   = 9'b1_0_1_0_0_0_0_0_0;
  localparam logic [8:0] C_INC  = 9'b0_0_0_0_1_0_0_0_0;

  initial begin
    logic [8:0] rc;
    logic       rr;
    // reset with every command high
    cycle(1'b1, 8'hAA, 8'h55, 9'h1FF);
    check("rst_pc",  {PCH, PCL}, 16'h0000);
    check("rst_err", {15'd0, CMD_ERR}, 16'd0);
    // load 0x12FE then increment twice
    cycle(1'b0, 8'hFE, 8'h12, C_LD);
    cycle(1'b0, 8'h00, 8'h00, C_INC);
    check("inc1_pc", {PCH, PCL}, 16'h12FF);
    check("inc1_pcc", {15'd0, PCC}, 16'd0);
    cycle(1'b0, 8'h00, 8'h00, C_INC);
    check("inc2_pc", {PCH, PCL}, 16'h1300);
    check("inc2_pcc", {15'd0, PCC}, 16'd1);
    // combined load + increment, then drive both buses
    cycle(1'b0, 8'h34, 8'hC0, C_LD | C_INC);
    check("ldinc_pc", {PCH, PCL}, 16'hC035);
    cycle(1'b0, 8'h00, 8'h00, 9'b0_0_0_0_0_1_1_0_0);
    // load PCL only with carry into PCH
    cycle(1'b0, 8'hFF, 8'h00, 9'b1_0_0_0_1_0_0_0_0);
    check("ldl_carry", {PCH, PCL}, 16'hC100);
    // wrap
    cycle(1'b0, 8'hFF, 8'hFF, C_LD);
    cycle(1'b0, 8'h00, 8'h00, C_INC);
    check("wrap_pc", {PCH, PCL}, 16'h0000);
    check("wrap_pcc", {15'd0, PCC}, 16'd1);
    // load conflict sets sticky error
    cycle(1'b0, 8'h80, 8'h00, 9'b1_1_0_0_0_0_0_0_0);
    check("conf_pcl", {8'd0, PCL}, 16'h0080);
    check("conf_err", {15'd0, CMD_ERR}, 16'd1);
    cycle(1'b0, 8'h00, 8'h00, C_NONE);
    check("err_sticky", {15'd0, CMD_ERR}, 16'd1);
    // drive conflict: DB shows PCL
    cycle(1'b0, 8'h00, 8'h00, 9'b0_0_0_0_0_0_0_1_1);
    // reset mid-increment
    cycle(1'b0, 8'hFF, 8'h00, C_LD);
    cycle(1'b1, 8'h00, 8'h00, C_INC);
    check("rstinc_pc", {PCH, PCL}, 16'h0000);
    check("rstinc_pcc", {15'd0, PCC}, 16'd0);
    check("rstinc_err", {15'd0, CMD_ERR}, 16'd0);
    // random traffic; conflicts and resets are kept rare so the error flag toggles
    for (int i = 0; i < 500; i++) begin
      rc = 9'($urandom);
      if ($urandom_range(7) != 0) begin
        rc[7] = rc[7] & rc[8] ? 1'b0 : rc[7];
        rc[5] = rc[5] & rc[6] ? 1'b0 : rc[5];
        rc[0] = rc[0] & rc[1] ? 1'b0 : rc[0];
      end
      if ($urandom_range(3) != 0) rc[4] = 1'b1;
      rr = ($urandom_range(31) == 0);
      cycle(rr, 8'($urandom), ($urandom_range(1) == 0) ? 8'hFF : 8'($urandom), rc);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
